// File: rtl/tagger_mc_pkg.sv
// tagger_mc_pkg: command codes and handshake states shared by the tagger DAQ
package tagger_mc_pkg;
  localparam logic [3:0] CMD_START      = 4'h1;
  localparam logic [3:0] CMD_STOP       = 4'h2;
  localparam logic [3:0] CMD_RESET_TIME = 4'h3;
  localparam logic [3:0] CMD_CLEAR_OVF  = 4'h4;
  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_REL} hs_state_e;
endpackage

// File: rtl/tagger_fifo.sv
// tagger_fifo: synchronous event FIFO with flush; a write into a full FIFO is accepted when a pop happens in the same cycle
// Ports: clk/rst (async, active-high), flush_i empties, wr_i/din_i push, rd_i pops,
// dout_o head word (combinational), full_o/empty_o flags, level_o occupancy.
module tagger_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wr_i,
  input  logic [W-1:0]             din_i,
  input  logic                     rd_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   lvl_q;
  logic          do_wr, do_rd;
  assign full_o  = lvl_q == (AW+1)'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign do_rd   = rd_i & ~empty_o;
  assign do_wr   = wr_i & (~full_o | do_rd);
  assign dout_o  = mem_q[rp_q];
  assign level_o = lvl_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(do_wr);
      rp_q  <= rp_q + AW'(do_rd);
      lvl_q <= lvl_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr && !flush_i) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/multi_tagger_daq.sv
// multi_tagger_daq: multi-channel edge tagger with timestamped event FIFO and host handshake
// Ports: clk_50 clock, reset async active-high; ch_in raw channels; cmd_code/cmd_valid commands;
// h2f_ack_evt/f2h_notify_evt host handshake; evt_ts/evt_mask/evt_seq presented event;
// enable_acq, fifo_level, ovf_cnt status.
// Build option: define TAGGER_OVF_CNT_EN to count dropped events and honour CLEAR_OVF.
module multi_tagger_daq import tagger_mc_pkg::*; #(
  parameter int N_CH       = 3,
  parameter int TS_W       = 48,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic [N_CH-1:0]               ch_in,
  input  logic [3:0]                    cmd_code,
  input  logic                          cmd_valid,
  input  logic                          h2f_ack_evt,
  output logic                          f2h_notify_evt,
  output logic [TS_W-1:0]               evt_ts,
  output logic [N_CH-1:0]               evt_mask,
  output logic [15:0]                   evt_seq,
  output logic                          enable_acq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   ovf_cnt
);
  localparam int W = 16 + N_CH + TS_W;
`ifdef TAGGER_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic [N_CH-1:0] s1_q, s2_q, s3_q, ev_mask_q, rise, evt_mask_q;
  logic [TS_W-1:0] ts_q, ev_ts_q, evt_ts_q;
  logic [15:0]     seq_q, ev_seq_q, evt_seq_q, ovf_q;
  logic            en_q, ev_vld_q, form, drop, full, empty, load, pop;
  logic            c_start, c_stop, c_rst, c_clr;
  logic [W-1:0]    head;
  hs_state_e       st_q, st_d;
  assign c_start = cmd_valid && cmd_code == CMD_START;
  assign c_stop  = cmd_valid && cmd_code == CMD_STOP;
  assign c_rst   = cmd_valid && cmd_code == CMD_RESET_TIME;
  assign c_clr   = cmd_valid && cmd_code == CMD_CLEAR_OVF;
  assign rise    = s2_q & ~s3_q;
  // enable_acq only drops the cycle after a STOP strobe, so a coincident edge is still formed
  assign form    = en_q && |rise && !c_rst;
  assign drop    = ev_vld_q && full && !pop && !c_rst;
  always_ff @(posedge clk_50 or posedge reset)
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      ts_q      <= '0;
      en_q      <= 1'b0;
      seq_q     <= '0;
      ev_vld_q  <= 1'b0;
      ev_mask_q <= '0;
      ev_ts_q   <= '0;
      ev_seq_q  <= '0;
      ovf_q     <= '0;
    end else begin
      s1_q      <= ch_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      ts_q      <= c_rst ? '0 : ts_q + TS_W'(1);
      en_q      <= c_start ? 1'b1 : c_stop ? 1'b0 : en_q;
      seq_q     <= c_rst ? '0 : seq_q + 16'(form);
      ev_vld_q  <= form;
      ev_mask_q <= rise;
      ev_ts_q   <= ts_q;
      ev_seq_q  <= seq_q;
      ovf_q     <= (c_clr && OVF_EN) ? '0 : (drop && OVF_EN && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
    end
  tagger_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_50),
    .rst     (reset),
    .flush_i (c_rst),
    .wr_i    (ev_vld_q),
    .din_i   ({ev_seq_q, ev_mask_q, ev_ts_q}),
    .rd_i    (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  always_ff @(posedge clk_50 or posedge reset)
    if (reset) begin
      st_q       <= IDLE;
      evt_ts_q   <= '0;
      evt_mask_q <= '0;
      evt_seq_q  <= '0;
    end else begin
      st_q <= st_d;
      if (load) begin
        evt_seq_q  <= head[W-1 -: 16];
        evt_mask_q <= head[TS_W +: N_CH];
        evt_ts_q   <= head[TS_W-1:0];
      end
    end
  // a RESET_TIME strobe flushes the FIFO, so the head must not be presented or kept presented
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:     st_d = (!empty && !h2f_ack_evt && !c_rst) ? PRESENT : IDLE;
      PRESENT:  st_d = c_rst ? IDLE : h2f_ack_evt ? WAIT_REL : PRESENT;
      WAIT_REL: st_d = h2f_ack_evt ? WAIT_REL : IDLE;
      default:  st_d = IDLE;
    endcase
  end
  always_comb begin
    f2h_notify_evt = st_q == PRESENT;
    load           = st_q == IDLE && st_d == PRESENT;
    pop            = st_q == PRESENT && h2f_ack_evt;
  end
  assign evt_ts     = evt_ts_q;
  assign evt_mask   = evt_mask_q;
  assign evt_seq    = evt_seq_q;
  assign enable_acq = en_q;
  assign ovf_cnt    = ovf_q;
endmodule

// File: tb/tb_multi_tagger_daq.sv
// tb_multi_tagger_daq: directed scoreboard bench for multi_tagger_daq
`define CK(t, o, e) check(t, 64'(o), 64'(e))
module tb_multi_tagger_daq;
  logic        clk_50, reset, cmd_valid, h2f_ack_evt, f2h_notify_evt, enable_acq;
  logic [2:0]  ch_in, evt_mask;
  logic [3:0]  cmd_code;
  logic [47:0] evt_ts, ts_m;
  logic [15:0] evt_seq, ovf_cnt, sq;
  logic [4:0]  fifo_level;
  int          total = 0, bad = 0;
  typedef struct packed { logic [47:0] ts; logic [2:0] mask; logic [15:0] seq; } ev_t;
  ev_t sb[$];
`ifdef TAGGER_OVF_CNT_EN
  localparam logic [15:0] OVF_EXP = 16'd4;
`else
  localparam logic [15:0] OVF_EXP = 16'd0;
`endif
  multi_tagger_daq dut (
    .clk_50(clk_50), .reset(reset), .ch_in(ch_in), .cmd_code(cmd_code), .cmd_valid(cmd_valid),
    .h2f_ack_evt(h2f_ack_evt), .f2h_notify_evt(f2h_notify_evt), .evt_ts(evt_ts), .evt_mask(evt_mask),
    .evt_seq(evt_seq), .enable_acq(enable_acq), .fifo_level(fifo_level), .ovf_cnt(ovf_cnt)
  );
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50 or posedge reset)
    if (reset) ts_m <= '0;
    else ts_m <= (cmd_valid && cmd_code == 4'h3) ? '0 : ts_m + 48'd1;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic fail(input string tag);
    bad++;
    $error("FAIL %s", tag);
  endtask
  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask
  task automatic cmd(input logic [3:0] c);
    cmd_code  = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_code  = 4'h0;
  endtask
  task automatic push(input logic [2:0] m);
    ev_t e;
    e.ts   = ts_m + 48'd2;
    e.mask = m;
    e.seq  = sq;
    sb.push_back(e);
    sq++;
  endtask
  task automatic pulse(input logic [2:0] m);
    ch_in = m;
    tick();
    tick();
    ch_in = '0;
  endtask
  task automatic wait_notify(input string tag);
    int n = 0;
    while (f2h_notify_evt !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    `CK({tag, "_notify"}, f2h_notify_evt, 1'b1);
  endtask
  task automatic expect_present(input string tag);
    ev_t e;
    wait_notify(tag);
    `CK({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      `CK({tag, "_mask"}, evt_mask, e.mask);
      `CK({tag, "_ts"}, evt_ts, e.ts);
      `CK({tag, "_seq"}, evt_seq, e.seq);
    end
  endtask
  task automatic ack_evt(input string tag);
    h2f_ack_evt = 1'b1;
    tick();
    `CK({tag, "_ack_notify_low"}, f2h_notify_evt, 1'b0);
    h2f_ack_evt = 1'b0;
    tick();
  endtask
  initial begin
    reset = 1'b1; ch_in = '0; cmd_code = '0; cmd_valid = 1'b0; h2f_ack_evt = 1'b0; sq = '0;
    repeat (3) @(posedge clk_50);
    #1 reset = 1'b0;
    total++; if (f2h_notify_evt !== 1'b0) fail("rst_notify");
    total++; if (enable_acq !== 1'b0) fail("rst_enable");
    total++; if (fifo_level !== 5'd0) fail("rst_level");
    total++; if (ovf_cnt !== 16'd0) fail("rst_ovf");
    total++; if (evt_ts !== 48'd0) fail("rst_ts");
    total++; if (evt_mask !== 3'd0) fail("rst_mask");
    total++; if (evt_seq !== 16'd0) fail("rst_seq");
    pulse(3'b010);
    repeat (6) tick();
    total++; if (fifo_level !== 5'd0) fail("idle_no_event_level");
    total++; if (f2h_notify_evt !== 1'b0) fail("idle_no_event_notify");
    cmd(4'h1);
    total++; if (enable_acq !== 1'b1) fail("start_enable");
    while (ts_m < 48'd98) tick();
    ch_in = 3'b010;
    push(3'b010);
    tick();
    tick();
    ch_in = '0;
    tick();
    total++; if (fifo_level !== 5'd0) fail("lat_k2_level");
    tick();
    total++; if (fifo_level !== 5'd1) fail("lat_k3_level");
    tick();
    total++; if (f2h_notify_evt !== 1'b1) fail("lat_notify");
    expect_present("ev_ch1");
    ack_evt("ev_ch1");
    total++; if (fifo_level !== 5'd0) fail("ev_ch1_popped");
    push(3'b101);
    pulse(3'b101);
    expect_present("ev_coinc");
    ack_evt("ev_coinc");
    h2f_ack_evt = 1'b1;
    push(3'b001);
    pulse(3'b001);
    repeat (8) tick();
    total++; if (f2h_notify_evt !== 1'b0) fail("ackhold_notify");
    total++; if (fifo_level !== 5'd1) fail("ackhold_level");
    h2f_ack_evt = 1'b0;
    expect_present("ackhold");
    ack_evt("ackhold");
    for (int i = 0; i < 20; i++) begin
      if (i < 16) push(3'b001);
      else sq++;
      pulse(3'b001);
      tick();
      tick();
    end
    repeat (4) tick();
    total++; if (fifo_level !== 5'd16) fail("ovf_level");
    total++; if (ovf_cnt !== OVF_EXP) fail("ovf_cnt");
    for (int i = 0; i < 16; i++) begin
      expect_present("ovf_drain");
      ack_evt("ovf_drain");
    end
    total++; if (fifo_level !== 5'd0) fail("ovf_drained");
    push(3'b100);
    pulse(3'b100);
    expect_present("ovf_seq_jump");
    ack_evt("ovf_seq_jump");
    cmd(4'h4);
    total++; if (ovf_cnt !== 16'd0) fail("clear_ovf");
    push(3'b010);
    pulse(3'b010);
    cmd(4'h2);
    total++; if (enable_acq !== 1'b0) fail("stop_enable");
    expect_present("stop_edge");
    ack_evt("stop_edge");
    pulse(3'b010);
    repeat (6) tick();
    total++; if (fifo_level !== 5'd0) fail("stopped_level");
    total++; if (f2h_notify_evt !== 1'b0) fail("stopped_notify");
    cmd(4'h1);
    pulse(3'b100);
    cmd(4'h3);
    sq = '0;
    repeat (6) tick();
    total++; if (fifo_level !== 5'd0) fail("rt_edge_level");
    total++; if (f2h_notify_evt !== 1'b0) fail("rt_edge_notify");
    push(3'b010);
    pulse(3'b010);
    tick();
    tick();
    push(3'b001);
    pulse(3'b001);
    wait_notify("rt_present");
    repeat (4) tick();
    total++; if (fifo_level !== 5'd2) fail("rt_present_level");
    cmd(4'h3);
    sb.delete();
    sq = '0;
    total++; if (f2h_notify_evt !== 1'b0) fail("rt_notify_low");
    total++; if (fifo_level !== 5'd0) fail("rt_level");
    push(3'b100);
    pulse(3'b100);
    expect_present("rt_after");
    total++; if (!(evt_ts < 48'd16)) fail("rt_after_ts_small");
    ack_evt("rt_after");
    push(3'b001);
    pulse(3'b001);
    wait_notify("midrst");
    #3 reset = 1'b1;
    #1;
    total++; if (f2h_notify_evt !== 1'b0) fail("midrst_notify");
    total++; if (enable_acq !== 1'b0) fail("midrst_enable");
    total++; if (fifo_level !== 5'd0) fail("midrst_level");
    total++; if (ovf_cnt !== 16'd0) fail("midrst_ovf");
    total++; if (evt_ts !== 48'd0) fail("midrst_ts");
    total++; if (evt_mask !== 3'd0) fail("midrst_mask");
    total++; if (evt_seq !== 16'd0) fail("midrst_seq");
    tick();
    reset = 1'b0;
    sb.delete();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_tagger_daq.md
MULTI_TAGGER_DAQ -- requirements
Module: multi_tagger_daq

Interface
REQ-001 Parameter N_CH, default 3, number of trigger/single input channels (1..16).
REQ-002 Parameter TS_W, default 48, timestamp counter width (16..64).
REQ-003 Parameter FIFO_DEPTH, default 16, event buffer depth (power of 2, >=4).
REQ-004 Port clk_50 input 1, the only clock; all logic SHALL run on it.
REQ-005 Port reset input 1, asynchronous active-high reset.
REQ-006 Port ch_in input N_CH, raw asynchronous channel inputs.
REQ-007 Port cmd_code input 4, command code from the command receiver.
REQ-008 Port cmd_valid input 1, one-cycle strobe qualifying cmd_code.
REQ-009 Port h2f_ack_evt input 1, host acknowledge of the presented event.
REQ-010 Port f2h_notify_evt output 1, event-presented flag to host.
REQ-011 Port evt_ts output TS_W, timestamp of the presented event.
REQ-012 Port evt_mask output N_CH, channels that fired in the presented event.
REQ-013 Port evt_seq output 16, sequence number of the presented event.
REQ-014 Port enable_acq output 1, acquisition running.
REQ-015 Port fifo_level output $clog2(FIFO_DEPTH)+1, events buffered.
REQ-016 Port ovf_cnt output 16, dropped-event count.

Function
REQ-017 Each ch_in bit SHALL pass a 2-flop synchronizer, then rising-edge detection; an edge registered at cycle k forms one event with ts = ts_cnt at cycle k and mask = all bits with coincident edges.
REQ-018 ts_cnt SHALL increment every cycle, wrapping modulo 2^TS_W to 0 with no flag.
REQ-019 Commands: 0x1 START sets enable_acq; 0x2 STOP clears it; 0x3 RESET_TIME zeroes ts_cnt and seq, flushes FIFO; 0x4 CLEAR_OVF zeroes ovf_cnt; other codes ignored; commands take effect the cycle after cmd_valid.
REQ-020 Events SHALL be formed only while enable_acq=1; an edge coincident with the STOP strobe is still accepted.
REQ-021 An edge coincident with the RESET_TIME strobe SHALL be discarded.
REQ-022 seq SHALL increment per formed event, including dropped ones, wrapping at 16 bits, so the host detects gaps.
REQ-023 Event write to FIFO SHALL occur one cycle after edge detection; ch_in rise sampled at cycle k is in the FIFO at k+3.
REQ-024 Full FIFO: event dropped, ovf_cnt incremented, saturating at 0xFFFF; simultaneous pop and write when full SHALL accept the write.
REQ-025 Handshake FSM states IDLE, PRESENT, WAIT_REL.
REQ-026 IDLE->PRESENT when FIFO non-empty and h2f_ack_evt=0; evt_* loaded from head; f2h_notify_evt=1 next cycle.
REQ-027 PRESENT->WAIT_REL on h2f_ack_evt=1: head popped, f2h_notify_evt=0; evt_* held.
REQ-028 WAIT_REL->IDLE on h2f_ack_evt=0.
REQ-029 evt_* SHALL be stable throughout PRESENT.
REQ-030 RESET_TIME in PRESENT SHALL force IDLE and drop notify, discarding that event; in WAIT_REL, state is unchanged.

Reset
REQ-031 On reset: enable_acq=0, ts_cnt=0, seq=0, FIFO empty, fifo_level=0, ovf_cnt=0, FSM IDLE, f2h_notify_evt=0, evt_ts/evt_mask/evt_seq=0, synchronizer and edge registers 0.

Configuration
REQ-032 Macro TAGGER_OVF_CNT_EN: defined -> ovf_cnt per REQ-024 and CLEAR_OVF honoured; undefined -> ovf_cnt tied 0, CLEAR_OVF ignored, drops still occur.

Structure
REQ-033 Package tagger_mc_pkg SHALL hold command-code constants (CMD_START, CMD_STOP, CMD_RESET_TIME, CMD_CLEAR_OVF) and the handshake-state enum.
REQ-034 Sub-module tagger_fifo: synchronous FIFO of {seq, mask, ts}, width 16+N_CH+TS_W, with flush, full, empty, level.

Verification
REQ-035 START, then pulse ch_in[1] at cycle 100 -> notify, evt_mask=3'b010, evt_ts=ts_cnt at edge detection, evt_seq=0.
REQ-036 ch_in[0] and ch_in[2] rise in the same cycle -> single event, evt_mask=3'b101.
REQ-037 No ack, 20 events, FIFO_DEPTH=16 -> fifo_level=16, ovf_cnt=4 (3 with one presented), next accepted evt_seq jumps accordingly.
REQ-038 RESET_TIME during PRESENT -> notify low next cycle, fifo_level=0, subsequent event evt_ts small, evt_seq=0.
REQ-039 Hold ack high across a new event -> FSM stays IDLE until ack low, then presents.
REQ-040 Reset asserted mid-handshake -> all outputs per REQ-031 immediately.
